kbd_fiodec_fifo: RTL and testbench

Parametrised PS/2-to-FIO-DEC typewriter input queue. It sits between the PS/2 key-event port and the CPU typewriter-input logic. It translates set-2 make codes into 7-bit {case, FIO-DEC} entries and buffers them in a 2^DEPTH_LOG2 FIFO. Beyond a plain key buffer, it adds:
- typematic-repeat suppression;
- automatic case-shift code insertion with a two-slot space reservation;
- sticky overflow reporting;
- an exposed fill level.

---
 rtl/kbd_fiodec_fifo.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_kbd_fiodec_fifo.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_fiodec_fifo.sv
// -----------------------------------------------------------------------------
// kbd_fiodec_fifo
//
// PS/2 (scan set 2) to FIO-DEC typewriter input queue. Key events arriving
// on ps2_key are translated into 7-bit {case, FIO-DEC} entries and buffered
// in a 2^DEPTH_LOG2-entry FIFO for the CPU typewriter-input logic.
// Optional features: typematic-repeat suppression, automatic case-shift code
// insertion (the case code and its character are reserved as a pair, so a
// lone case code is never queued), sticky overflow and fill level.
//
// Ports
//   clk                in   system clock, posedge
//   rst_n              in   asynchronous active-low reset
//   ps2_key[10:0]      in   [10] event toggle, [9] 1=make/0=break,
//                           [8:0] scan code ([8] = E0 extended)
//   enable             in   typewriter selected; when low nothing is queued
//   key_was_processed  in   consumer acknowledge; rising edge pops the head
//   overflow_clr       in   synchronous clear of overflow
//   kbd_read_strobe    out  head entry valid and not yet acknowledged
//   kbd_char_out[6:0]  out  head entry: [6] case (1 = upper), [5:0] FIO-DEC
//   fill_level         out  number of stored entries (0 .. 2^DEPTH_LOG2)
//   overflow           out  sticky: an event was dropped because of no room
//
// Handshake: an entry is offered while kbd_read_strobe is high; the consumer
// takes it by raising key_was_processed (edge-detected after a register
// stage). kbd_read_strobe then drops for at least one cycle before the next
// entry is presented.
// -----------------------------------------------------------------------------
module kbd_fiodec_fifo #(
    parameter int DEPTH_LOG2      = 3,
    parameter bit CASE_TRACK      = 1'b1,
    parameter bit REPEAT_SUPPRESS = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [10:0]           ps2_key,
    input  logic                  enable,
    input  logic                  key_was_processed,
    input  logic                  overflow_clr,
    output logic                  kbd_read_strobe,
    output logic [6:0]            kbd_char_out,
    output logic [DEPTH_LOG2:0]   fill_level,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2+1:0] DEPTH_W = (DEPTH_LOG2+2)'(DEPTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CHAR = 1'b1
    } state_e;

    // Returns {hit, fio_dec}; extended codes never match.
    function automatic logic [6:0] xlate(input logic [8:0] sc);
        logic [6:0] r;
        r = 7'd0;
        case (sc)
            9'h045: r = {1'b1, 6'o20};
            9'h016: r = {1'b1, 6'o01};
            9'h01E: r = {1'b1, 6'o02};
            9'h026: r = {1'b1, 6'o03};
            9'h025: r = {1'b1, 6'o04};
            9'h02E: r = {1'b1, 6'o05};
            9'h036: r = {1'b1, 6'o06};
            9'h03D: r = {1'b1, 6'o07};
            9'h03E: r = {1'b1, 6'o10};
            9'h046: r = {1'b1, 6'o11};
            9'h01C: r = {1'b1, 6'o61};
            9'h032: r = {1'b1, 6'o62};
            9'h021: r = {1'b1, 6'o63};
            9'h023: r = {1'b1, 6'o64};
            9'h024: r = {1'b1, 6'o65};
            9'h02B: r = {1'b1, 6'o66};
            9'h034: r = {1'b1, 6'o67};
            9'h033: r = {1'b1, 6'o70};
            9'h043: r = {1'b1, 6'o71};
            9'h03B: r = {1'b1, 6'o41};
            9'h042: r = {1'b1, 6'o42};
            9'h04B: r = {1'b1, 6'o43};
            9'h03A: r = {1'b1, 6'o44};
            9'h031: r = {1'b1, 6'o45};
            9'h044: r = {1'b1, 6'o46};
            9'h04D: r = {1'b1, 6'o47};
            9'h015: r = {1'b1, 6'o50};
            9'h02D: r = {1'b1, 6'o51};
            9'h01B: r = {1'b1, 6'o22};
            9'h02C: r = {1'b1, 6'o23};
            9'h03C: r = {1'b1, 6'o24};
            9'h02A: r = {1'b1, 6'o25};
            9'h01D: r = {1'b1, 6'o26};
            9'h022: r = {1'b1, 6'o27};
            9'h035: r = {1'b1, 6'o30};
            9'h01A: r = {1'b1, 6'o31};
            9'h029: r = {1'b1, 6'o00};
            9'h00D: r = {1'b1, 6'o36};
            9'h05A: r = {1'b1, 6'o77};
            9'h066: r = {1'b1, 6'o75};
            9'h041: r = {1'b1, 6'o33};
            9'h055: r = {1'b1, 6'o33};
            9'h04A: r = {1'b1, 6'o21};
            9'h049: r = {1'b1, 6'o73};
            9'h04E: r = {1'b1, 6'o54};
            9'h054: r = {1'b1, 6'o57};
            9'h05B: r = {1'b1, 6'o55};
            9'h05D: r = {1'b1, 6'o56};
            9'h07C: r = {1'b1, 6'o40};
            9'h058: r = {1'b1, 6'o36};
            default: r = 7'd0;
        endcase
        return r;
    endfunction

    // Registers
    logic [10:0]           key_q;
    logic                  key_vld_q;     // key_q holds a real sample
    logic                  primed_q;      // last_toggle_q loaded after reset
    logic                  last_toggle_q;
    logic                  ack_q;
    logic                  ack_prev_q;
    state_e                state_q;
    logic                  shift_q;       // physical shift key state
    logic                  case_q;        // case of the last emitted case code
    logic                  held_q;
    logic [8:0]            held_code_q;
    logic [5:0]            pend_q;        // character waiting behind a case code
    logic [6:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   fill_q;
    logic [DEPTH_LOG2:0]   fill_d;
    logic                  ovf_q;
    logic                  strobe_q;
    logic [6:0]            char_q;

    // Event decode
    logic                  evt;
    logic                  is_shift;
    logic [6:0]            xl;
    logic                  tr_hit;
    logic [5:0]            tr_code;
    logic                  held_match;
    logic                  suppress;
    logic                  want;
    logic                  need_case;
    logic                  pop;
    logic [DEPTH_LOG2+1:0] free_slots;
    logic                  fits;
    logic                  push_case;
    logic                  push_plain;
    logic                  drop;
    logic                  push;
    logic [6:0]            wdata;

    always_comb begin
        evt        = primed_q && (state_q == ST_IDLE) && (key_q[10] != last_toggle_q);
        is_shift   = (key_q[8:0] == 9'h012) || (key_q[8:0] == 9'h059);
        xl         = xlate(key_q[8:0]);
        tr_hit     = xl[6];
        tr_code    = xl[5:0];
        held_match = held_q && (held_code_q == key_q[8:0]);
        suppress   = REPEAT_SUPPRESS && held_match;
        want       = evt && tr_hit && key_q[9] && !suppress && enable;
        need_case  = CASE_TRACK && (shift_q != case_q);
        pop        = ack_q && !ack_prev_q && (fill_q != '0);
        // A pop at the same edge frees its slot for this edge's write.
        free_slots = DEPTH_W - {1'b0, fill_q} + {{(DEPTH_LOG2+1){1'b0}}, pop};
        fits       = free_slots >= (need_case ? (DEPTH_LOG2+2)'(2) : (DEPTH_LOG2+2)'(1));
        push_case  = want && fits && need_case;
        push_plain = want && fits && !need_case;
        drop       = want && !fits;
        push       = push_case || push_plain || (state_q == ST_CHAR);

        if (state_q == ST_CHAR) begin
            wdata = {case_q, pend_q};
        end else if (push_case) begin
            wdata = {shift_q, (shift_q ? 6'o74 : 6'o72)};
        end else begin
            wdata = {shift_q, tr_code};
        end

        case ({push, pop})
            2'b10:   fill_d = fill_q + (DEPTH_LOG2+1)'(1);
            2'b01:   fill_d = fill_q - (DEPTH_LOG2+1)'(1);
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q         <= '0;
            key_vld_q     <= 1'b0;
            primed_q      <= 1'b0;
            last_toggle_q <= 1'b0;
            ack_q         <= 1'b0;
            ack_prev_q    <= 1'b0;
            state_q       <= ST_IDLE;
            shift_q       <= 1'b0;
            case_q        <= 1'b0;
            held_q        <= 1'b0;
            held_code_q   <= '0;
            pend_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fill_q        <= '0;
            ovf_q         <= 1'b0;
            strobe_q      <= 1'b0;
            char_q        <= '0;
        end else begin
            key_q      <= ps2_key;
            key_vld_q  <= 1'b1;
            ack_q      <= key_was_processed;
            ack_prev_q <= ack_q;

            // The first real sample only establishes the toggle reference.
            if (key_vld_q && !primed_q) begin
                last_toggle_q <= key_q[10];
                primed_q      <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (evt) begin
                        last_toggle_q <= key_q[10];
                        if (is_shift) begin
                            shift_q <= key_q[9];
                        end else if (tr_hit) begin
                            if (key_q[9]) begin
                                if (!suppress) begin
                                    held_q      <= 1'b1;
                                    held_code_q <= key_q[8:0];
                                end
                            end else if (held_match) begin
                                held_q <= 1'b0;
                            end
                        end
                        if (push_case) begin
                            case_q  <= shift_q;
                            pend_q  <= tr_code;
                            state_q <= ST_CHAR;
                        end
                    end
                end
                ST_CHAR: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase

            if (push) begin
                wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            end
            fill_q <= fill_d;

            if (drop) begin
                ovf_q <= 1'b1;
            end else if (overflow_clr) begin
                ovf_q <= 1'b0;
            end

            strobe_q <= pop ? 1'b0 : (fill_q != '0);
            if (fill_q != '0) begin
                char_q <= mem[rd_ptr_q];
            end
        end
    end

    assign kbd_read_strobe = strobe_q;
    assign kbd_char_out    = char_q;
    assign fill_level      = fill_q;
    assign overflow        = ovf_q;

endmodule

// File: tb/tb_kbd_fiodec_fifo.sv
// -----------------------------------------------------------------------------
// Testbench for kbd_fiodec_fifo (DEPTH_LOG2=3, CASE_TRACK=1, REPEAT_SUPPRESS=1).
// Stimulus pushes expected entries into exp_q from a reference model built
// from the translation rules; a monitor acknowledges and compares entries.
// -----------------------------------------------------------------------------
module tb_kbd_fiodec_fifo;

    localparam int DL    = 3;
    localparam int DEPTH = 8;

    // Clock / reset
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [10:0]   ps2_key;
    logic          enable;
    logic          overflow_clr;
    logic          ack_mon;
    logic          ack_man;
    logic          key_was_processed;
    logic          kbd_read_strobe;
    logic [6:0]    kbd_char_out;
    logic [DL:0]   fill_level;
    logic          overflow;

    assign key_was_processed = ack_mon | ack_man;

    always #5 clk = ~clk;

    kbd_fiodec_fifo #(
        .DEPTH_LOG2(DL),
        .CASE_TRACK(1'b1),
        .REPEAT_SUPPRESS(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ps2_key(ps2_key),
        .enable(enable),
        .key_was_processed(key_was_processed),
        .overflow_clr(overflow_clr),
        .kbd_read_strobe(kbd_read_strobe),
        .kbd_char_out(kbd_char_out),
        .fill_level(fill_level),
        .overflow(overflow)
    );

    // Scoreboard and reference model state
    logic [6:0]  exp_q[$];
    logic [5:0]  trans [logic [8:0]];
    logic [8:0]  tr_codes[$];
    logic [8:0]  letter_sc [26];
    logic [8:0]  digit_sc [10];
    int          n_checks = 0;
    int          n_fail = 0;
    logic        cons_en = 1'b0;
    logic        tog;
    bit          m_shift, m_case, m_held, m_ovf;
    logic [8:0]  m_held_code;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void add_tr(input logic [8:0] sc, input logic [5:0] v);
        trans[sc] = v;
        tr_codes.push_back(sc);
    endfunction

    // Reference model: applies the key-event rules to the model state.
    function automatic void model_key(input bit mk, input logic [8:0] code);
        int need;
        logic [5:0] fc;
        if (code == 9'h012 || code == 9'h059) begin
            m_shift = mk;
            return;
        end
        if (!trans.exists(code)) return;
        fc = trans[code];
        if (!mk) begin
            if (m_held && m_held_code == code) m_held = 1'b0;
            return;
        end
        if (m_held && m_held_code == code) return;
        m_held = 1'b1;
        m_held_code = code;
        if (!enable) return;
        need = (m_shift != m_case) ? 2 : 1;
        if (DEPTH - exp_q.size() < need) begin
            m_ovf = 1'b1;
            return;
        end
        if (need == 2) begin
            exp_q.push_back({m_shift, (m_shift ? 6'o74 : 6'o72)});
            m_case = m_shift;
        end
        exp_q.push_back({m_shift, fc});
    endfunction

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_key(input bit mk, input logic [8:0] code);
        tog = ~tog;
        ps2_key = {tog, mk, code};
        model_key(mk, code);
    endtask

    task automatic send(input bit mk, input logic [8:0] code);
        @(negedge clk);
        drive_key(mk, code);
        tick(5);
    endtask

    task automatic clr_ovf();
        @(negedge clk);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        m_ovf = 1'b0;
        tick(2);
    endtask

    task automatic drain();
        int t;
        t = 0;
        cons_en = 1'b1;
        while ((exp_q.size() != 0 || fill_level != 0) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("drain_done", (t < 2000) ? 32'd1 : 32'd0, 32'd1);
        tick(6);
        cons_en = 1'b0;
        check("drain_fill", 32'(fill_level), 32'd0);
    endtask

    // Monitor: compares each presented entry, acknowledges it, and checks
    // the strobe drops after the pop.
    initial begin
        logic [6:0] e;
        ack_mon = 1'b0;
        forever begin
            @(negedge clk);
            if (cons_en && rst_n && kbd_read_strobe) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL entry_unexpected: got %0o expected none", kbd_char_out);
                end else begin
                    e = exp_q.pop_front();
                    check("entry", 32'(kbd_char_out), 32'(e));
                end
                ack_mon = 1'b1;
                @(negedge clk);
                @(negedge clk);
                check("strobe_drop", 32'(kbd_read_strobe), 32'd0);
                ack_mon = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Main sequence
    initial begin
        logic [6:0] e;
        logic [8:0] last_code;
        logic [5:0] v;
        int r;

        letter_sc = '{9'h01C, 9'h032, 9'h021, 9'h023, 9'h024, 9'h02B, 9'h034, 9'h033, 9'h043,
                      9'h03B, 9'h042, 9'h04B, 9'h03A, 9'h031, 9'h044, 9'h04D, 9'h015, 9'h02D,
                      9'h01B, 9'h02C, 9'h03C, 9'h02A, 9'h01D, 9'h022, 9'h035, 9'h01A};
        digit_sc  = '{9'h045, 9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E, 9'h036, 9'h03D, 9'h03E, 9'h046};
        for (int i = 0; i < 26; i++) begin
            if (i < 9)       v = 6'o61 + 6'(i);
            else if (i < 18) v = 6'o41 + 6'(i - 9);
            else             v = 6'o22 + 6'(i - 18);
            add_tr(letter_sc[i], v);
        end
        for (int d = 0; d < 10; d++) add_tr(digit_sc[d], (d == 0) ? 6'o20 : 6'(d));
        add_tr(9'h029, 6'o00); add_tr(9'h00D, 6'o36); add_tr(9'h05A, 6'o77);
        add_tr(9'h066, 6'o75); add_tr(9'h041, 6'o33); add_tr(9'h055, 6'o33);
        add_tr(9'h04A, 6'o21); add_tr(9'h049, 6'o73); add_tr(9'h04E, 6'o54);
        add_tr(9'h054, 6'o57); add_tr(9'h05B, 6'o55); add_tr(9'h05D, 6'o56);
        add_tr(9'h07C, 6'o40); add_tr(9'h058, 6'o36);

        m_shift = 1'b0; m_case = 1'b0; m_held = 1'b0; m_ovf = 1'b0; m_held_code = '0;
        tog = 1'b1;
        ps2_key = {1'b1, 1'b0, 9'h000};
        enable = 1'b1;
        overflow_clr = 1'b0;
        ack_man = 1'b0;

        // Reset values
        tick(3);
        check("rst_strobe", 32'(kbd_read_strobe), 32'd0);
        check("rst_char", 32'(kbd_char_out), 32'd0);
        check("rst_fill", 32'(fill_level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;

        // Toggle held high from reset is not an event
        tick(6);
        check("prime_no_event", 32'(fill_level), 32'd0);

        // First toggle: 'a'
        send(1'b1, 9'h01C);
        check("first_fill", 32'(fill_level), 32'd1);
        check("first_strobe", 32'(kbd_read_strobe), 32'd1);
        check("first_char", 32'(kbd_char_out), 32'o061);
        send(1'b0, 9'h01C);
        drain();

        // Shift + 'a' inserts the upper-case code
        send(1'b1, 9'h012);
        send(1'b1, 9'h01C);
        check("case_fill", 32'(fill_level), 32'd2);
        check("case_head", 32'(kbd_char_out), 32'o174);
        send(1'b0, 9'h012);
        send(1'b0, 9'h01C);
        drain();

        // Repeat suppression (case returns to lower first)
        send(1'b1, 9'h01C);
        send(1'b1, 9'h01C);
        send(1'b1, 9'h01C);
        send(1'b0, 9'h01C);
        send(1'b1, 9'h01C);
        check("repeat_fill", 32'(fill_level), 32'd3);
        send(1'b0, 9'h01C);
        drain();

        // Disabled: nothing queued, shift still tracked
        enable = 1'b0;
        send(1'b1, 9'h012);
        send(1'b1, 9'h016);
        check("dis_fill", 32'(fill_level), 32'd0);
        check("dis_overflow", 32'(overflow), 32'd0);
        send(1'b0, 9'h016);
        enable = 1'b1;
        send(1'b1, 9'h01C);
        check("dis_case_fill", 32'(fill_level), 32'd2);
        check("dis_case_head", 32'(kbd_char_out), 32'o174);
        send(1'b0, 9'h012);
        send(1'b0, 9'h01C);
        drain();
        send(1'b1, 9'h01C);
        send(1'b0, 9'h01C);
        drain();

        // Overflow: 9 makes into 8 slots
        for (int i = 1; i <= 9; i++) send(1'b1, letter_sc[i]);
        check("full_fill", 32'(fill_level), 32'd8);
        check("full_overflow", 32'(overflow), 32'd1);
        clr_ovf();
        check("ovf_clr", 32'(overflow), 32'd0);
        drain();

        // 7 entries + case-changing key: whole event dropped
        for (int i = 10; i <= 16; i++) send(1'b1, letter_sc[i]);
        check("seven_fill", 32'(fill_level), 32'd7);
        send(1'b1, 9'h012);
        send(1'b1, letter_sc[17]);
        check("pair_drop_fill", 32'(fill_level), 32'd7);
        check("pair_drop_ovf", 32'(overflow), 32'd1);
        clr_ovf();
        send(1'b0, 9'h012);
        send(1'b1, letter_sc[18]);
        check("refill_fill", 32'(fill_level), 32'd8);

        // Pop and write at the same edge while full
        @(negedge clk);
        e = exp_q.pop_front();
        check("wrap_head", 32'(kbd_char_out), 32'(e));
        ack_man = 1'b1;
        drive_key(1'b1, letter_sc[19]);
        tick(2);
        ack_man = 1'b0;
        tick(4);
        check("wrap_fill", 32'(fill_level), 32'd8);
        check("wrap_overflow", 32'(overflow), 32'd0);
        drain();

        // Ignored pop on empty FIFO coinciding with a push
        @(negedge clk);
        ack_man = 1'b1;
        drive_key(1'b1, letter_sc[20]);
        tick(2);
        ack_man = 1'b0;
        tick(4);
        check("empty_pop_fill", 32'(fill_level), 32'd1);
        drain();

        // Randomized traffic with the consumer running
        cons_en = 1'b1;
        last_code = letter_sc[20];
        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 9);
            if (r <= 4) begin
                last_code = tr_codes[$urandom_range(0, tr_codes.size() - 1)];
                send($urandom_range(0, 3) != 0, last_code);
            end else if (r == 5) begin
                send($urandom_range(0, 1) == 1, ($urandom_range(0, 1) == 1) ? 9'h012 : 9'h059);
            end else if (r == 6) begin
                send(1'b1, last_code);
            end else if (r == 7) begin
                send(1'b0, last_code);
            end else if (r == 8) begin
                send(1'b1, ($urandom_range(0, 1) == 1) ? 9'h11C : 9'h076);
            end else begin
                @(negedge clk);
                enable = ~enable;
            end
            tick(20);
        end
        enable = 1'b1;
        drain();
        check("rand_overflow", 32'(overflow), 32'(m_ovf));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
